alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter_pkg.sv | 21 ++
 rtl/alu_share_arbiter_rr_arb2.sv | 42 ++++
 rtl/alu_share_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: execute command encodings,
// status-register bit positions and the response-buffer state type.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ADD_EXE = 4'd0;
  localparam logic [3:0] SUB_EXE = 4'd1;
  localparam logic [3:0] ADC_EXE = 4'd2;
  localparam logic [3:0] SBC_EXE = 4'd3;
  localparam logic [3:0] AND_EXE = 4'd4;
  localparam logic [3:0] ORR_EXE = 4'd5;
  localparam logic [3:0] EOR_EXE = 4'd6;
  localparam logic [3:0] MOV_EXE = 4'd7;

  localparam int unsigned SR_Z = 3;
  localparam int unsigned SR_C = 2;
  localparam int unsigned SR_N = 1;
  localparam int unsigned SR_V = 0;

  typedef enum logic {StEmpty, StFull} buf_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input arbiter. With ALU_ARB_RR_EN defined it is round-robin on a
// `last` pointer (reset to 1 so port 0 wins the first tie); otherwise fixed priority to port 0.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (update) last_d = gnt[1];
  end

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, update};

  always_comb begin
    gnt = req;
    if (req[0]) gnt = 2'b01;
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with one-deep response
// buffers and an architectural {Z,C,N,V} register. Round-robin via ALU_ARB_RR_EN.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_val1,
  input  logic [W-1:0]     req0_val2,
  input  logic [CMD_W-1:0] req0_cmd,
  input  logic             req0_cin,
  input  logic             req0_use_c,
  input  logic             req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_val1,
  input  logic [W-1:0]     req1_val2,
  input  logic [CMD_W-1:0] req1_cmd,
  input  logic             req1_cin,
  input  logic             req1_use_c,
  input  logic             req1_s,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [W-1:0]     rsp0_result,
  output logic [3:0]       rsp0_sr,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [W-1:0]     rsp1_result,
  output logic [3:0]       rsp1_sr,
  output logic [W-1:0]     alu_val1,
  output logic [W-1:0]     alu_val2,
  output logic             alu_cin,
  output logic [CMD_W-1:0] alu_cmd,
  input  logic [W-1:0]     alu_result,
  input  logic [3:0]       alu_sr,
  output logic [3:0]       sr
);

  buf_state_e buf_q [2];
  buf_state_e buf_d [2];
  logic [1:0] req_valid, rsp_ready, elig, gnt;
  logic [W-1:0] result_q [2];
  logic [3:0]   rsp_sr_q [2];
  logic [3:0]   sr_q;
  logic         sr_we;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (elig),
    .update (|gnt),
    .gnt    (gnt)
  );

  // Buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= StEmpty;
      buf_q[1] <= StEmpty;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
    end
  end

  // Buffer next state: drain-and-refill in one cycle keeps it full
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      buf_d[n] = buf_q[n];
      unique case (buf_q[n])
        StEmpty: if (gnt[n]) buf_d[n] = StFull;
        StFull:  if (rsp_ready[n] && !gnt[n]) buf_d[n] = StEmpty;
        default: buf_d[n] = StEmpty;
      endcase
    end
  end

  // Buffer-derived outputs and eligibility
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      elig[n] = req_valid[n] & ((buf_q[n] == StEmpty) | rsp_ready[n]);
    end
    rsp0_valid = (buf_q[0] == StFull);
    rsp1_valid = (buf_q[1] == StFull);
    req0_ready = gnt[0];
    req1_ready = gnt[1];
  end

  // ALU drive; port 0 is the idle default so the ALU inputs stay quiet
  always_comb begin
    if (gnt[1]) begin
      alu_val1 = req1_val1;
      alu_val2 = req1_val2;
      alu_cmd  = req1_cmd;
      alu_cin  = req1_use_c ? sr_q[SR_C] : req1_cin;
    end else begin
      alu_val1 = req0_val1;
      alu_val2 = req0_val2;
      alu_cmd  = req0_cmd;
      alu_cin  = req0_use_c ? sr_q[SR_C] : req0_cin;
    end
  end

  assign sr_we = (gnt[0] & req0_s) | (gnt[1] & req1_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q[0] <= '0;
      result_q[1] <= '0;
      rsp_sr_q[0] <= '0;
      rsp_sr_q[1] <= '0;
      sr_q        <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (gnt[n]) begin
          result_q[n] <= alu_result;
          rsp_sr_q[n] <= alu_sr;
        end
      end
      if (sr_we) sr_q <= alu_sr;
    end
  end

  assign rsp0_result = result_q[0];
  assign rsp1_result = result_q[1];
  assign rsp0_sr     = rsp_sr_q[0];
  assign rsp1_sr     = rsp_sr_q[1];
  assign sr          = sr_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_cin, req0_use_c, req0_s;
  logic        req1_valid, req1_ready, req1_cin, req1_use_c, req1_s;
  logic [31:0] req0_val1, req0_val2, req1_val1, req1_val2;
  logic [3:0]  req0_cmd, req1_cmd;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  rsp0_sr, rsp1_sr, sr;
  logic [31:0] alu_val1, alu_val2, alu_result;
  logic        alu_cin;
  logic [3:0]  alu_cmd, alu_sr;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter #(.W(32), .CMD_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_val1(req0_val1),
    .req0_val2(req0_val2), .req0_cmd(req0_cmd), .req0_cin(req0_cin),
    .req0_use_c(req0_use_c), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_val1(req1_val1),
    .req1_val2(req1_val2), .req1_cmd(req1_cmd), .req1_cin(req1_cin),
    .req1_use_c(req1_use_c), .req1_s(req1_s),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_sr(rsp0_sr),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_sr(rsp1_sr),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cin(alu_cin), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_sr(alu_sr), .sr(sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: flags {Z,C,N,V}, subtract as a + ~b + 1
  logic [32:0] sum;
  logic [31:0] opb;
  always_comb begin
    opb = alu_val2;
    sum = '0;
    case (alu_cmd)
      ADD_EXE: sum = {1'b0, alu_val1} + {1'b0, alu_val2};
      ADC_EXE: sum = {1'b0, alu_val1} + {1'b0, alu_val2} + {32'd0, alu_cin};
      SUB_EXE: begin
        opb = ~alu_val2;
        sum = {1'b0, alu_val1} + {1'b0, opb} + 33'd1;
      end
      SBC_EXE: begin
        opb = ~alu_val2;
        sum = {1'b0, alu_val1} + {1'b0, opb} + {32'd0, alu_cin};
      end
      default: sum = {1'b0, alu_val1 & alu_val2};
    endcase
    alu_result = sum[31:0];
    alu_sr = {sum[31:0] == 32'd0, sum[32], sum[31],
              (alu_val1[31] == opb[31]) && (sum[31] != alu_val1[31])};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic v0, v1, rr0, rr1;
    logic [3:0] cmd0; logic [31:0] a0, b0; logic c0, uc0, s0;
    logic [3:0] cmd1; logic [31:0] a1, b1; logic c1, uc1, s1;
    logic erdy0, erdy1;
    logic erv0; logic [31:0] eres0; logic [3:0] ersr0;
    logic erv1; logic [31:0] eres1; logic [3:0] ersr1;
    logic [3:0] esr;
  } vec_t;

  vec_t vecs [8];

  task automatic idle_inputs();
    req0_valid = 0; req0_val1 = 0; req0_val2 = 0; req0_cmd = ADD_EXE;
    req0_cin = 0; req0_use_c = 0; req0_s = 0;
    req1_valid = 0; req1_val1 = 0; req1_val2 = 0; req1_cmd = ADD_EXE;
    req1_cin = 0; req1_use_c = 0; req1_s = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  initial begin
    // v0 v1 rr0 rr1 | port0 cmd,a,b,cin,use_c,s | port1 ... | rdy0 rdy1 |
    // rv0 res0 rsr0 | rv1 res1 rsr1 | sr
    vecs[0] = '{1, 0, 0, 0, ADD_EXE, 32'h7FFFFFFF, 32'h1, 0, 0, 1,
                ADD_EXE, 32'h0, 32'h0, 0, 0, 0, 1, 0,
                1, 32'h80000000, 4'b0011, 0, 32'h0, 4'b0000, 4'b0011};
    // Buffer 0 full and not drained: port 1 wins; sets Z and C
    vecs[1] = '{1, 1, 0, 0, ADD_EXE, 32'h1, 32'h1, 0, 0, 0,
                ADD_EXE, 32'hFFFFFFFF, 32'h1, 0, 0, 1, 0, 1,
                1, 32'h80000000, 4'b0011, 1, 32'h0, 4'b1100, 4'b1100};
    // Drain-and-refill on port 0 with carry taken from the stored C flag
    vecs[2] = '{1, 0, 1, 0, ADC_EXE, 32'h0, 32'h0, 0, 1, 1,
                ADD_EXE, 32'h0, 32'h0, 0, 0, 0, 1, 0,
                1, 32'h1, 4'b0000, 1, 32'h0, 4'b1100, 4'b0000};
    // s = 0 subtract: response flags show Z, sr untouched
    vecs[3] = '{1, 0, 1, 1, SUB_EXE, 32'd5, 32'd5, 0, 0, 0,
                ADD_EXE, 32'h0, 32'h0, 0, 0, 0, 1, 0,
                1, 32'h0, 4'b1100, 0, 32'h0, 4'b1100, 4'b0000};
    vecs[4] = '{0, 0, 1, 1, ADD_EXE, 32'h0, 32'h0, 0, 0, 0,
                ADD_EXE, 32'h0, 32'h0, 0, 0, 0, 0, 0,
                0, 32'h0, 4'b1100, 0, 32'h0, 4'b1100, 4'b0000};
    // use_c with stored C = 0 overrides an explicit cin = 1
    vecs[5] = '{0, 1, 0, 0, ADD_EXE, 32'h0, 32'h0, 0, 0, 0,
                ADC_EXE, 32'd10, 32'd20, 1, 1, 1, 0, 1,
                0, 32'h0, 4'b1100, 1, 32'd30, 4'b0000, 4'b0000};
    vecs[6] = '{1, 0, 0, 0, ADC_EXE, 32'd10, 32'd20, 1, 0, 1,
                ADD_EXE, 32'h0, 32'h0, 0, 0, 0, 1, 0,
                1, 32'd31, 4'b0000, 1, 32'd30, 4'b0000, 4'b0000};
    vecs[7] = '{1, 0, 1, 0, SUB_EXE, 32'd3, 32'd5, 0, 0, 1,
                ADD_EXE, 32'h0, 32'h0, 0, 0, 0, 1, 0,
                1, 32'hFFFFFFFE, 4'b0010, 1, 32'd30, 4'b0000, 4'b0010};

    idle_inputs();
    rst_n = 0;
    #3;
    chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("reset_sr", {28'd0, sr}, 32'd0);
    chk("reset_rsp0_result", rsp0_result, 32'd0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req0_valid = vecs[i].v0; req0_cmd = vecs[i].cmd0; req0_val1 = vecs[i].a0;
      req0_val2 = vecs[i].b0; req0_cin = vecs[i].c0; req0_use_c = vecs[i].uc0;
      req0_s = vecs[i].s0;
      req1_valid = vecs[i].v1; req1_cmd = vecs[i].cmd1; req1_val1 = vecs[i].a1;
      req1_val2 = vecs[i].b1; req1_cin = vecs[i].c1; req1_use_c = vecs[i].uc1;
      req1_s = vecs[i].s1;
      rsp0_ready = vecs[i].rr0; rsp1_ready = vecs[i].rr1;
      #1;
      chk($sformatf("v%0d_req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].erdy0});
      chk($sformatf("v%0d_req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].erdy1});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp0_valid", i), {31'd0, rsp0_valid}, {31'd0, vecs[i].erv0});
      chk($sformatf("v%0d_rsp0_result", i), rsp0_result, vecs[i].eres0);
      chk($sformatf("v%0d_rsp0_sr", i), {28'd0, rsp0_sr}, {28'd0, vecs[i].ersr0});
      chk($sformatf("v%0d_rsp1_valid", i), {31'd0, rsp1_valid}, {31'd0, vecs[i].erv1});
      chk($sformatf("v%0d_rsp1_result", i), rsp1_result, vecs[i].eres1);
      chk($sformatf("v%0d_rsp1_sr", i), {28'd0, rsp1_sr}, {28'd0, vecs[i].ersr1});
      chk($sformatf("v%0d_sr", i), {28'd0, sr}, {28'd0, vecs[i].esr});
    end

    // Asynchronous reset mid-cycle with both buffers full
    @(negedge clk);
    idle_inputs();
    #2;
    rst_n = 0;
    #1;
    chk("midrst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("midrst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("midrst_sr", {28'd0, sr}, 32'd0);
    chk("midrst_rsp0_result", rsp0_result, 32'd0);
    @(negedge clk);
    rst_n = 1;
    req0_valid = 1;
    #1;
    chk("post_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
    req0_valid = 0;

    // Both ports continuously eligible
    for (int i = 0; i < 4; i++) begin
      logic exp_g1;
`ifdef ALU_ARB_RR_EN
      exp_g1 = (i % 2 == 1);
`else
      exp_g1 = 1'b0;
`endif
      @(negedge clk);
      req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
      req0_val1 = i; req1_val1 = 32'h100 + i;
      #1;
      chk($sformatf("tie%0d_req0_ready", i), {31'd0, req0_ready}, {31'd0, !exp_g1});
      chk($sformatf("tie%0d_req1_ready", i), {31'd0, req1_ready}, {31'd0, exp_g1});
      @(posedge clk);
    end

    @(negedge clk);
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
